// File: rtl/ps2_cmd_seq_pkg.sv
// ---------------------------------------------------------------------------
// ps2_cmd_seq_pkg
// Shared definitions for the PS/2 command sequencer:
//   - PS/2 device response bytes (ACK / RESEND)
//   - cmd_status encodings reported with cmd_done
//   - sequencer FSM state type
//   - saturating 8-bit increment used by the error counter
// ---------------------------------------------------------------------------
package ps2_cmd_seq_pkg;

  // Device responses to a host command byte
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Completion status of a command
  typedef enum logic [1:0] {
    ST_ACK     = 2'b00,
    ST_RESEND  = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_WAIT = 2'b10
  } state_e;

  // Increment that sticks at 8'hFF instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ---------------------------------------------------------------------------
// ps2_rx_fifo
// Synchronous show-ahead FIFO for bytes received from the PS/2 device.
// dout always presents the oldest entry; pop consumes it.
// A pop on empty is ignored. A push on full is dropped unless a pop happens
// in the same cycle, in which case both take effect.
// Full/empty are derived from pointers carrying one extra wrap bit.
//
// Ports
//   clk    in   clock
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write din this cycle
//   pop    in   consume the head entry this cycle
//   din    in   8-bit write data
//   dout   out  8-bit head entry (valid while !empty)
//   empty  out  no entries held
//   full   out  2**FIFO_AW entries held
// ---------------------------------------------------------------------------
module ps2_rx_fifo #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Same index with differing wrap bits means the writer is a full lap ahead
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[FIFO_AW-1:0]];

  // NOTE: clocked state is assigned with <= so every register samples
  // pre-edge values regardless of statement or block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the storage array has no reset; entries are only observable
  // after being written, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_cmd_seq.sv
// ---------------------------------------------------------------------------
// ps2_cmd_seq
// Command sequencer between the host bus and the PS/2 host controller.
// Sends one command byte at a time, waits for the device ACK (0xFA),
// retransmits on RESEND (0xFE) or a corrupted response up to MAX_RETRY
// times, and gives up after a response timeout. Every other received byte
// is queued in a small FIFO for the host.
//
// Parameters
//   ACK_TIMEOUT  cycles from the transmit handshake to the timeout cmd_done
//   MAX_RETRY    retransmissions allowed before reporting RESEND failure
//   FIFO_AW      receive FIFO address width (depth 2**FIFO_AW)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   cmd_valid/data  host offers a command byte
//   cmd_ready       sequencer idle, next command accepted
//   cmd_done        one-cycle pulse: command finished
//   cmd_status      00 ACK, 01 RESEND limit, 10 TIMEOUT; held until next done
//   key_data        FIFO head (show-ahead)
//   key_valid       FIFO not empty
//   key_ack         pop FIFO head
//   key_ovfl        sticky: a byte was dropped on a full FIFO
//   err_cnt         saturating count of bytes received with error
//   p_rcv_*         received byte / error flag / strobe from PS/2 controller
//   p_xmt_ready     PS/2 controller can start a transmission
//   p_xmt_data      byte to transmit (the latched command)
//   p_xmt_strobe    transmit request
// ---------------------------------------------------------------------------
module ps2_cmd_seq
  import ps2_cmd_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 3,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       rst,
  // host command interface
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic [1:0] cmd_status,
  // host receive-byte interface
  output logic [7:0] key_data,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_ovfl,
  output logic [7:0] err_cnt,
  // PS/2 controller interface
  input  logic [7:0] p_rcv_data,
  input  logic       p_rcv_error,
  input  logic       p_rcv_strobe,
  input  logic       p_xmt_ready,
  output logic [7:0] p_xmt_data,
  output logic       p_xmt_strobe
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e        state;
  status_e       status_q;
  logic [7:0]    cmd_q;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;

  logic          rx_ok;
  logic          rx_err;
  logic          is_ack;
  logic          is_resend;
  logic          can_retry;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;

  // -------------------------------------------------------------------------
  // Receive decode
  // -------------------------------------------------------------------------
  assign rx_err    = p_rcv_strobe && p_rcv_error;
  assign rx_ok     = p_rcv_strobe && !p_rcv_error;
  assign is_ack    = rx_ok && (p_rcv_data == PS2_ACK);
  assign is_resend = rx_ok && (p_rcv_data == PS2_RESEND);
  assign can_retry = (retry < RW'(MAX_RETRY));

  // Only while a command waits for its response are ACK/RESEND consumed by
  // the sequencer; at any other time they are ordinary data for the host.
  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    fifo_push = 1'b0;
    if (rx_ok) begin
      fifo_push = (state != S_WAIT) || (!is_ack && !is_resend);
    end
  end

  assign fifo_pop = key_ack;

  ps2_rx_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (p_rcv_data),
    .dout  (key_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign key_valid = !fifo_empty;

  // -------------------------------------------------------------------------
  // Command FSM, retry counter and response timer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      status_q <= ST_ACK;
      cmd_q    <= '0;
      retry    <= '0;
      timer    <= '0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd_data;
            retry <= '0;
            state <= S_SEND;
          end
        end

        S_SEND: begin
          // The handshake cycle counts as the first cycle of the response
          // window, so cmd_done on timeout lands ACK_TIMEOUT cycles after it.
          if (p_xmt_ready) begin
            timer <= TW'(ACK_TIMEOUT - 1);
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Holding at zero means a data byte arriving on the last cycle
          // defers the timeout by one cycle instead of wrapping the timer.
          if (timer != '0) timer <= timer - TW'(1);

          if (rx_err || is_resend) begin
            if (can_retry) begin
              retry <= retry + RW'(1);
              state <= S_SEND;
            end else begin
              status_q <= ST_RESEND;
              cmd_done <= 1'b1;
              state    <= S_IDLE;
            end
          end else if (is_ack) begin
            status_q <= ST_ACK;
            cmd_done <= 1'b1;
            state    <= S_IDLE;
          end else if (!p_rcv_strobe && (timer == '0)) begin
            status_q <= ST_TIMEOUT;
            cmd_done <= 1'b1;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state == S_IDLE);
  assign cmd_status   = status_q;
  assign p_xmt_data   = cmd_q;
  assign p_xmt_strobe = (state == S_SEND);

  // -------------------------------------------------------------------------
  // Receive error counter and FIFO overflow flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt  <= '0;
      key_ovfl <= 1'b0;
    end else begin
      if (rx_err) err_cnt <= sat_inc8(err_cnt);

      // A drop can only happen without a pop, so the two never collide
      if (fifo_pop && key_valid) begin
        key_ovfl <= 1'b0;
      end else if (fifo_push && fifo_full) begin
        key_ovfl <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_cmd_seq.sv
`timescale 1ns/1ps
module tb_ps2_cmd_seq;
  import ps2_cmd_seq_pkg::*;

  localparam int ACK_TIMEOUT = 200;
  localparam int MAX_RETRY   = 3;
  localparam int FIFO_AW     = 3;
  localparam int DEPTH       = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       cmd_done;
  logic [1:0] cmd_status;
  logic [7:0] key_data;
  logic       key_valid;
  logic       key_ack;
  logic       key_ovfl;
  logic [7:0] err_cnt;
  logic [7:0] p_rcv_data;
  logic       p_rcv_error;
  logic       p_rcv_strobe;
  logic       p_xmt_ready;
  logic [7:0] p_xmt_data;
  logic       p_xmt_strobe;

  ps2_cmd_seq #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY),
    .FIFO_AW     (FIFO_AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .cmd_done     (cmd_done),
    .cmd_status   (cmd_status),
    .key_data     (key_data),
    .key_valid    (key_valid),
    .key_ack      (key_ack),
    .key_ovfl     (key_ovfl),
    .err_cnt      (err_cnt),
    .p_rcv_data   (p_rcv_data),
    .p_rcv_error  (p_rcv_error),
    .p_rcv_strobe (p_rcv_strobe),
    .p_xmt_ready  (p_xmt_ready),
    .p_xmt_data   (p_xmt_data),
    .p_xmt_strobe (p_xmt_strobe)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  typedef enum int {K_OTHER, K_ACK, K_RESEND, K_ERR, K_NONE} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] data;
    int         gap;
  } resp_t;
  typedef struct {
    logic [1:0] status;
    int         hs;
    bit         timed;
  } exp_cmd_t;

  resp_t      script[$];
  exp_cmd_t   exp_cmd_q[$];
  logic [7:0] exp_key_q[$];
  int         exp_err  = 0;
  bit         exp_ovfl = 1'b0;

  int checks = 0;
  int errors = 0;

  int  cyc      = 0;
  int  hs_cnt   = 0;
  int  hs_cyc   = 0;
  int  done_cnt = 0;
  bit  pop_en   = 1'b1;
  logic mon_ack = 1'b0;
  logic man_ack = 1'b0;

  assign key_ack = mon_ack | man_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter and per-command handshake counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || cmd_done) begin
      hs_cnt <= 0;
    end else if (p_xmt_strobe && p_xmt_ready) begin
      hs_cnt <= hs_cnt + 1;
      hs_cyc <= cyc + 1;
    end
  end

  // Command completion monitor
  initial begin
    exp_cmd_t e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_done) begin
        done_cnt++;
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_done: got unexpected pulse, status %0h (t=%0t)", cmd_status, $time);
        end else begin
          e = exp_cmd_q.pop_front();
          check("cmd_status", cmd_status, e.status);
          check("handshakes", hs_cnt, e.hs);
          check("cmd_ready_at_done", cmd_ready, 1);
          if (e.timed) check("timeout_latency", cyc - hs_cyc, ACK_TIMEOUT);
        end
      end
    end
  end

  // Receive-byte monitor: pops the FIFO and compares against the model
  initial begin
    forever begin
      @(negedge clk);
      mon_ack = 1'b0;
      if (pop_en && !rst && key_valid) begin
        if (exp_key_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL key_data: got unexpected byte %0h (t=%0t)", key_data, $time);
        end else begin
          check("key_data", key_data, exp_key_q.pop_front());
        end
        exp_ovfl = 1'b0;
        mon_ack  = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (all called at posedge + #1)
  // ---------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic resp_t mk(input kind_e k, input logic [7:0] d, input int g);
    resp_t r;
    r.kind = k;
    r.data = d;
    r.gap  = g;
    return r;
  endfunction

  function automatic logic [7:0] rnd_other();
    return 8'($urandom_range(0, 249));
  endfunction

  // Deliver one byte; the model decides from the protocol rules whether the
  // byte belongs in the host FIFO and whether it fits.
  task automatic rcv(input logic [7:0] d, input bit err, input bit in_wait);
    p_rcv_data   = d;
    p_rcv_error  = err;
    p_rcv_strobe = 1'b1;
    if (err) begin
      exp_err++;
    end else if (!in_wait || (d != PS2_ACK && d != PS2_RESEND)) begin
      if (pop_en || exp_key_q.size() < DEPTH) exp_key_q.push_back(d);
      else exp_ovfl = 1'b1;
    end
    cycles(1);
    p_rcv_strobe = 1'b0;
    p_rcv_error  = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] c);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = c;
    cycles(1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_handshake(input logic [7:0] c, input int ready_delay);
    bit ok = 1'b0;
    cycles(ready_delay);
    p_xmt_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (p_xmt_strobe) begin
        ok = 1'b1;
        break;
      end
    end
    check("xmt_strobe_seen", ok, 1);
    if (ok) check("p_xmt_data", p_xmt_data, c);
    @(posedge clk);
    #1;
    p_xmt_ready = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 3 * ACK_TIMEOUT; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) break;
    end
    check("cmd_done_seen", done_cnt != d0, 1);
    cycles(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_key_q.size() == 0 && !key_valid) break;
    end
    check("fifo_drained", exp_key_q.size(), 0);
    cycles(1);
  endtask

  // Run one command against the current script. The expected outcome is
  // derived from the count of failed responses alone.
  task automatic run_cmd(input logic [7:0] c, input bit rx_in_send);
    exp_cmd_t e;
    resp_t    r;
    int       fails = 0;
    bit       none  = 1'b0;
    int       d0;
    foreach (script[i]) begin
      if (script[i].kind == K_RESEND || script[i].kind == K_ERR) fails++;
      if (script[i].kind == K_NONE) none = 1'b1;
    end
    e.hs     = (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
    e.status = (fails > MAX_RETRY) ? ST_RESEND : (none ? ST_TIMEOUT : ST_ACK);
    e.timed  = none && (fails <= MAX_RETRY);
    exp_cmd_q.push_back(e);
    d0 = done_cnt;

    issue_cmd(c);
    if (rx_in_send) begin
      rcv(PS2_ACK, 1'b0, 1'b0);
      rcv(PS2_RESEND, 1'b0, 1'b0);
    end
    do_handshake(c, $urandom_range(0, 3));
    while (script.size() > 0) begin
      r = script.pop_front();
      cycles(r.gap);
      case (r.kind)
        K_OTHER: begin
          cmd_valid = 1'b1;
          cmd_data  = ~c;
          rcv(r.data, 1'b0, 1'b1);
          cmd_valid = 1'b0;
        end
        K_ACK:    rcv(PS2_ACK, 1'b0, 1'b1);
        K_RESEND: rcv(PS2_RESEND, 1'b0, 1'b1);
        K_ERR:    rcv(r.data, 1'b1, 1'b1);
        default:  ;
      endcase
      if ((r.kind == K_RESEND || r.kind == K_ERR) && script.size() > 0)
        do_handshake(c, $urandom_range(0, 3));
    end
    wait_done(d0);
    check("err_cnt", err_cnt, exp_err);
  endtask

  task automatic add_others();
    int n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) script.push_back(mk(K_OTHER, rnd_other(), $urandom_range(0, 4)));
  endtask

  task automatic gen_random_script();
    int    f = $urandom_range(0, 4);
    kind_e k;
    script.delete();
    for (int i = 0; i < f; i++) begin
      add_others();
      k = ($urandom_range(0, 1) != 0) ? K_RESEND : K_ERR;
      script.push_back(mk(k, 8'($urandom), $urandom_range(0, 4)));
    end
    if (f <= MAX_RETRY) begin
      add_others();
      k = ($urandom_range(0, 4) == 0) ? K_NONE : K_ACK;
      script.push_back(mk(k, 8'h00, $urandom_range(0, 4)));
    end
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    logic [7:0] b;
    int         d0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = 8'h00;
    p_rcv_data = 8'h00;
    p_rcv_error = 1'b0;
    p_rcv_strobe = 1'b0;
    p_xmt_ready = 1'b0;
    cycles(3);
    rst = 1'b0;

    // Reset state
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cmd_done", cmd_done, 0);
    check("rst_cmd_status", cmd_status, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_ovfl", key_ovfl, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_xmt_strobe", p_xmt_strobe, 0);

    // Plain ACK
    script.delete();
    script.push_back(mk(K_ACK, 8'h00, 2));
    run_cmd(8'hED, 1'b0);

    // Three RESENDs then ACK; four RESENDs exhaust the retries
    script.delete();
    repeat (3) script.push_back(mk(K_RESEND, 8'h00, 1));
    script.push_back(mk(K_ACK, 8'h00, 1));
    run_cmd(8'hFF, 1'b0);
    script.delete();
    repeat (4) script.push_back(mk(K_RESEND, 8'h00, 1));
    run_cmd(8'hFF, 1'b0);

    // No response: timeout
    script.delete();
    script.push_back(mk(K_NONE, 8'h00, 0));
    run_cmd(8'hF2, 1'b0);

    // ACK on the last cycle of the window wins over the timeout
    script.delete();
    script.push_back(mk(K_ACK, 8'h00, ACK_TIMEOUT - 1));
    run_cmd(8'hF2, 1'b0);

    // Data bytes ahead of the ACK are queued in order
    script.delete();
    script.push_back(mk(K_OTHER, 8'hAB, 1));
    script.push_back(mk(K_OTHER, 8'h83, 0));
    script.push_back(mk(K_ACK, 8'h00, 1));
    run_cmd(8'hF2, 1'b0);

    // FA/FE arriving before the handshake are data for the host
    script.delete();
    script.push_back(mk(K_ACK, 8'h00, 3));
    run_cmd(8'hF4, 1'b1);

    // Corrupted response triggers a retransmit and counts an error
    script.delete();
    script.push_back(mk(K_ERR, 8'hFA, 2));
    script.push_back(mk(K_ACK, 8'h00, 2));
    run_cmd(8'hF3, 1'b0);

    // Random commands
    for (int n = 0; n < 25; n++) begin
      gen_random_script();
      run_cmd(8'($urandom), 1'b0);
    end
    drain();

    // FIFO fill, overflow, pop+push on full
    pop_en = 1'b0;
    cycles(2);
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = (i == 2) ? PS2_ACK : (i == 5) ? PS2_RESEND : rnd_other();
      rcv(b, 1'b0, 1'b0);
    end
    check("ovfl_after_9", key_ovfl, exp_ovfl);
    check("ovfl_model_set", exp_ovfl, key_valid);
    check("full_head", key_data, exp_key_q[0]);
    void'(exp_key_q.pop_front());
    exp_ovfl = 1'b0;
    man_ack = 1'b1;
    rcv(8'h5A, 1'b0, 1'b0);
    man_ack = 1'b0;
    check("ovfl_after_pop_push", key_ovfl, exp_ovfl);
    rcv(8'h77, 1'b0, 1'b0);
    check("ovfl_after_drop", key_ovfl, exp_ovfl);
    void'(exp_key_q.pop_front());
    exp_ovfl = 1'b0;
    man_ack = 1'b1;
    cycles(1);
    man_ack = 1'b0;
    check("ovfl_cleared_by_pop", key_ovfl, exp_ovfl);
    check("head_after_pop", key_data, exp_key_q[0]);
    pop_en = 1'b1;
    drain();

    // Pop on empty is ignored
    man_ack = 1'b1;
    cycles(1);
    man_ack = 1'b0;
    check("empty_pop_valid", key_valid, exp_key_q.size() != 0);
    rcv(8'h3C, 1'b0, 1'b0);
    drain();

    // Reset while waiting for a response aborts without cmd_done
    d0 = done_cnt;
    issue_cmd(8'hEE);
    do_handshake(8'hEE, 1);
    cycles(5);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    exp_err = 0;
    exp_ovfl = 1'b0;
    exp_key_q.delete();
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_err_cnt", err_cnt, exp_err);
    check("abort_xmt_strobe", p_xmt_strobe, 0);
    cycles(ACK_TIMEOUT + 20);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_key_valid", key_valid, 0);

    check("cmd_queue_empty", exp_cmd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
